// File: rtl/md5_round_type_2.sv
// One registered MD5 step for the second round group (G function, schedule g = 5i+1 mod 16).
// Computes the rotated next A/B/C/D state with a fixed one-cycle latency.
module md5_round_type_2 (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [31:0]  k_in,
  input  logic [4:0]   shift_amount,
  input  logic [5:0]   round_num,
  input  logic [511:0] message,
  output logic         out_valid,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out
);

  // Handshake: in_valid qualifies every input on the rising edge; out_valid is
  // high for exactly the cycle after an accepted input. There is no ready and
  // no backpressure, so a new step may be presented every cycle.

  logic [31:0] g_func;
  logic [8:0]  g_prod;
  logic [3:0]  g_idx;
  logic [8:0]  word_base;
  logic [31:0] m_word;
  logic [31:0] f_sum;
  logic [63:0] rot_wide;
  logic [31:0] r_rot;
  logic [31:0] b_next;

  always_comb begin
    g_func    = (b_in & d_in) | (c_in & ~d_in);
    // Index taken from round_num as-is; callers outside 16..31 still get a defined word.
    g_prod    = (9'(round_num) * 9'd5) + 9'd1;
    g_idx     = g_prod[3:0];
    word_base = {g_idx, 5'b00000};
    m_word    = message[word_base +: 32];
    f_sum     = a_in + g_func + k_in + m_word;
    // Shifting the doubled word keeps shift_amount=0 well defined (no 32-bit shift).
    rot_wide  = {f_sum, f_sum} << shift_amount;
    r_rot     = rot_wide[63:32];
    b_next    = b_in + r_rot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_out     <= 32'd0;
      b_out     <= 32'd0;
      c_out     <= 32'd0;
      d_out     <= 32'd0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      a_out     <= d_in;
      b_out     <= b_next;
      c_out     <= b_in;
      d_out     <= c_in;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_md5_round_type_2.sv
// Directed bench for md5_round_type_2: reset, nominal vector, schedule sweep,
// rotate/overflow, back-to-back, hold and mid-stream reset.
module tb_md5_round_type_2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [31:0]  a_in, b_in, c_in, d_in, k_in;
  logic [4:0]   shift_amount;
  logic [5:0]   round_num;
  logic [511:0] message;
  logic         out_valid;
  logic [31:0]  a_out, b_out, c_out, d_out;

  int checks = 0;
  int errors = 0;

  md5_round_type_2 dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .a_in         (a_in),
    .b_in         (b_in),
    .c_in         (c_in),
    .d_in         (d_in),
    .k_in         (k_in),
    .shift_amount (shift_amount),
    .round_num    (round_num),
    .message      (message),
    .out_valid    (out_valid),
    .a_out        (a_out),
    .b_out        (b_out),
    .c_out        (c_out),
    .d_out        (d_out)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  // checking task
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d, input logic [31:0] k,
                       input logic [4:0] s, input logic [5:0] rn, input logic [511:0] msg);
    in_valid     = v;
    a_in         = a;
    b_in         = b;
    c_in         = c;
    d_in         = d;
    k_in         = k;
    shift_amount = s;
    round_num    = rn;
    message      = msg;
  endtask

  // Advance one edge and settle outputs before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    check_eq({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check_eq({tag, ".a"}, a_out, a);
    check_eq({tag, ".b"}, b_out, b);
    check_eq({tag, ".c"}, c_out, c);
    check_eq({tag, ".d"}, d_out, d);
  endtask

  logic [511:0] nibble_msg;
  logic [511:0] uniq_msg;
  logic [511:0] one_msg;
  logic [31:0]  exp_q[$];

  initial begin
    for (int j = 0; j < 16; j++) begin
      nibble_msg[32*j +: 32] = {8{j[3:0]}};
      uniq_msg[32*j +: 32]   = 32'(j + 1) << 4;
    end

    // Reset held 2 cycles with in_valid high.
    rst = 1'b1;
    drive(1'b1, 32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476,
          32'hd76aa478, 5'd7, 6'd0, nibble_msg);
    tick();
    tick();
    check_state("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;

    // Nominal vector, hand-computed: F=d8496112, R=24b0896c.
    tick();
    check_state("nominal", 1'b1, 32'h10325476, 32'h147e34f5, 32'hefcdab89, 32'h98badcfe);

    // Schedule sweep: word j holds (j+1)<<4, so b_out names the word picked.
    for (int i = 16; i < 32; i++) begin
      exp_q.push_back(32'(((5 * i + 1) % 16) + 1) << 4);
      drive(1'b1, 0, 0, 0, 0, 0, 5'd0, 6'(i), uniq_msg);
      tick();
      check_eq($sformatf("sweep_i%0d", i), b_out, exp_q.pop_front());
    end

    // Single non-zero word at the expected slot vs. a neighbouring slot.
    one_msg = '0;
    one_msg[32*1 +: 32] = 32'h1;            // i=16 -> g=1
    drive(1'b1, 0, 0, 0, 0, 0, 5'd0, 6'd16, one_msg);
    tick();
    check_eq("single_hit", b_out, 32'h1);
    drive(1'b1, 0, 0, 0, 0, 0, 5'd0, 6'd17, one_msg);  // i=17 -> g=6
    tick();
    check_eq("single_miss", b_out, 32'h0);

    // Out-of-group index: round_num=0 uses word 1.
    drive(1'b1, 0, 0, 0, 0, 0, 5'd0, 6'd0, one_msg);
    tick();
    check_eq("round0_g1", b_out, 32'h1);

    // Rotate/overflow, back-to-back with shift 31 then shift 0.
    drive(1'b1, 32'hffffffff, 0, 0, 0, 32'h2, 5'd31, 6'd20, '0);
    tick();
    check_state("rot31", 1'b1, 32'h0, 32'h80000000, 32'h0, 32'h0);
    drive(1'b1, 32'hffffffff, 0, 0, 0, 32'h2, 5'd0, 6'd20, '0);
    tick();
    check_state("rot0", 1'b1, 32'h0, 32'h00000001, 32'h0, 32'h0);

    // Back-to-back: nominal then a second distinct vector.
    drive(1'b1, 32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476,
          32'hd76aa478, 5'd7, 6'd0, nibble_msg);
    tick();
    check_state("b2b_0", 1'b1, 32'h10325476, 32'h147e34f5, 32'hefcdab89, 32'h98badcfe);
    // G=(b&d)|(c&~d)=0000ffff, F=0000ffff+1+word1(0x20)=00010020, rotl4=00100200.
    drive(1'b1, 32'h0, 32'h12345678, 32'h0000ffff, 32'h0, 32'h1, 5'd4, 6'd16, uniq_msg);
    tick();
    check_state("b2b_1", 1'b1, 32'h0, 32'h12445878, 32'h12345678, 32'h0000ffff);

    // Hold: in_valid low with new inputs leaves outputs alone.
    drive(1'b0, 32'hdeadbeef, 32'hcafef00d, 32'h11111111, 32'h22222222,
          32'h3, 5'd9, 6'd25, nibble_msg);
    tick();
    check_state("hold", 1'b0, 32'h0, 32'h12445878, 32'h12345678, 32'h0000ffff);
    tick();
    check_state("hold2", 1'b0, 32'h0, 32'h12445878, 32'h12345678, 32'h0000ffff);

    // Mid-stream reset: valid input in the reset cycle is discarded.
    drive(1'b1, 32'hffffffff, 0, 0, 0, 32'h2, 5'd31, 6'd20, '0);
    tick();
    check_eq("pre_rst.b", b_out, 32'h80000000);
    rst = 1'b1;
    drive(1'b1, 32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476,
          32'hd76aa478, 5'd7, 6'd0, nibble_msg);
    tick();
    check_state("mid_rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    check_state("post_rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
